// File: rtl/pc_seq_pkg.sv
// Shared types for the PC / FENCE sequencer.
// FSM state enum and the sequential PC step.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    RESUME
  } pc_seq_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_fence_sequencer_if.sv
// Control/status bundle of the PC fence sequencer.
// slave = sequencer side, master = front-end side.
interface pc_fence_sequencer_if #(
  parameter int CNT_W = 4
);

  logic              restart;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              fence;
  logic              mem_issue;
  logic              mem_ack;
  logic [31:0]       pc;
  logic              pc_valid;
  logic              fence_busy;
  logic [31:0]       predecessor;
  logic [31:0]       successor;
  logic [CNT_W-1:0]  outstanding;
  logic              cnt_err;
  logic              timeout_err;

  modport master (
    output restart, stall,
    output redirect_valid, redirect_pc,
    output fence, mem_issue, mem_ack,
    input  pc, pc_valid, fence_busy,
    input  predecessor, successor,
    input  outstanding, cnt_err, timeout_err
  );

  modport slave (
    input  restart, stall,
    input  redirect_valid, redirect_pc,
    input  fence, mem_issue, mem_ack,
    output pc, pc_valid, fence_busy,
    output predecessor, successor,
    output outstanding, cnt_err, timeout_err
  );

endinterface

// File: rtl/mem_outstanding_ctr.sv
// Saturating count of memory ops in flight.
// err is sticky on overflow or underflow.
module mem_outstanding_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic             issue,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] count_d, count_q;
  logic             err_d, err_q;

  // up/down step, clamped at both ends
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (restart) begin
      count_d = '0;
    end else if (issue && !ack) begin
      if (count_q == MAX) err_d = 1'b1;
      else count_d = count_q + 1'b1;
    end else if (ack && !issue) begin
      if (count_q == '0) err_d = 1'b1;
      else count_d = count_q - 1'b1;
    end
  end

  // counter and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/pc_fence_sequencer.sv
// Fetch PC register with stall/redirect and FENCE drain.
// Optional drain watchdog: PC_FENCE_TIMEOUT_EN.
module pc_fence_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 4,
  parameter int          TIMEOUT  = 256
) (
  input logic                 clk,
  input logic                 reset,
  pc_fence_sequencer_if.slave bus
);

  pc_seq_state_t    state_d, state_q;
  logic [31:0]      pc_d, pc_q;
  logic [31:0]      pred_d, pred_q;
  logic [31:0]      succ_d, succ_q;
  logic [CNT_W-1:0] outstanding;
  logic             cnt_err;
  logic             wd_hit;

  mem_outstanding_ctr #(
    .CNT_W (CNT_W)
  ) u_ctr (
    .clk     (clk),
    .rst_n   (reset),
    .restart (bus.restart),
    .issue   (bus.mem_issue),
    .ack     (bus.mem_ack),
    .count   (outstanding),
    .err     (cnt_err)
  );

  // next PC / state: restart > redirect > fence > stall
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pred_d  = pred_q;
    succ_d  = succ_q;
    if (bus.restart) begin
      state_d = RUN;
      pc_d    = RESET_PC;
    end else if (bus.redirect_valid) begin
      state_d = RUN;
      pc_d    = bus.redirect_pc & ~32'd3;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.fence) begin
            pred_d  = pc_q;
            succ_d  = pc_q + PC_STEP;
            state_d = DRAIN;
          end else if (!bus.stall) begin
            pc_d = pc_q + PC_STEP;
          end
        end
        DRAIN: begin
          if (outstanding == '0 || wd_hit)
            state_d = RESUME;
        end
        RESUME: begin
          pc_d    = succ_q;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // PC, state and fence record registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pred_q  <= '0;
      succ_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pred_q  <= pred_d;
      succ_q  <= succ_d;
    end
  end

`ifdef PC_FENCE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_d, wd_q;
  logic            terr_d, terr_q;

  // drain watchdog, zero outside DRAIN
  always_comb begin
    wd_d   = wd_q;
    terr_d = terr_q;
    wd_hit = 1'b0;
    if (state_q != DRAIN) begin
      wd_d = '0;
    end else if (outstanding != '0) begin
      if (wd_q == WD_LAST) wd_hit = 1'b1;
      else wd_d = wd_q + 1'b1;
    end
    if (wd_hit && !bus.restart &&
        !bus.redirect_valid)
      terr_d = 1'b1;
  end

  // watchdog count and sticky expiry flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign wd_hit          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = (state_q == RUN) & ~bus.stall;
  assign bus.fence_busy  = (state_q != RUN);
  assign bus.predecessor = pred_q;
  assign bus.successor   = succ_q;
  assign bus.outstanding = outstanding;
  assign bus.cnt_err     = cnt_err;

endmodule

// File: tb/tb_pc_fence_sequencer.sv
// Scoreboard bench for pc_fence_sequencer.
// Directed scenarios then randomized traffic.
module tb_pc_fence_sequencer;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int CW   = 4;
  localparam int CMAX = 15;
  localparam int TMO  = 8;

  typedef struct packed {
    logic [31:0]   pc;
    logic          pc_valid;
    logic          fence_busy;
    logic [31:0]   pred;
    logic [31:0]   succ;
    logic [CW-1:0] outs;
    logic          cerr;
    logic          terr;
  } obs_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  obs_t sb[$];
  obs_t mon_e;
  obs_t mon_a;

  // reference: fetch PC, fence record, drain/resume flags
  logic [31:0] m_pc, m_pred, m_succ;
  int          m_cnt, m_wd;
  bit          m_cerr, m_terr;
  bit          m_drain, m_resume;

  pc_fence_sequencer_if #(.CNT_W(CW)) bus ();

  pc_fence_sequencer #(
    .RESET_PC (RST_PC),
    .CNT_W    (CW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t expect_now(bit st);
    obs_t e;
    e.pc         = m_pc;
    e.fence_busy = m_drain | m_resume;
    e.pc_valid   = ~e.fence_busy & ~st;
    e.pred       = m_pred;
    e.succ       = m_succ;
    e.outs       = CW'(m_cnt);
    e.cerr       = m_cerr;
    e.terr       = m_terr;
    return e;
  endfunction

  task automatic drive(bit rs, bit st, bit rv,
                       logic [31:0] rpc, bit fe,
                       bit iss, bit ack);
    bus.restart        = rs;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.fence          = fe;
    bus.mem_issue      = iss;
    bus.mem_ack        = ack;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    m_pc = RST_PC; m_pred = '0; m_succ = '0;
    m_cnt = 0; m_wd = 0;
    m_cerr = 0; m_terr = 0;
    m_drain = 0; m_resume = 0;
    sb.push_back(expect_now(1'b0));
  endtask

  task automatic step(bit rs, bit st, bit rv,
                      logic [31:0] rpc, bit fe,
                      bit iss, bit ack);
    int c0;
    @(negedge clk);
    reset = 1'b1;
    drive(rs, st, rv, rpc, fe, iss, ack);
    c0 = m_cnt;
    if (rs) begin
      m_pc = RST_PC; m_drain = 0; m_resume = 0;
    end else if (rv) begin
      m_pc = rpc & 32'hFFFF_FFFC;
      m_drain = 0; m_resume = 0;
    end else if (m_resume) begin
      m_pc = m_succ; m_resume = 0;
    end else if (m_drain) begin
      if (c0 == 0) begin
        m_drain = 0; m_resume = 1;
      end
`ifdef PC_FENCE_TIMEOUT_EN
      else begin
        m_wd++;
        if (m_wd == TMO) begin
          m_terr = 1; m_drain = 0; m_resume = 1;
        end
      end
`endif
    end else if (fe) begin
      m_pred = m_pc; m_succ = m_pc + 32'd4;
      m_drain = 1; m_wd = 0;
    end else if (!st) begin
      m_pc = m_pc + 32'd4;
    end
    if (rs) m_cnt = 0;
    else if (iss && !ack) begin
      if (m_cnt == CMAX) m_cerr = 1;
      else m_cnt++;
    end else if (ack && !iss) begin
      if (m_cnt == 0) m_cerr = 1;
      else m_cnt--;
    end
    sb.push_back(expect_now(st));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  // monitor: compare every post-edge output set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        mon_a.pc         = bus.pc;
        mon_a.pc_valid   = bus.pc_valid;
        mon_a.fence_busy = bus.fence_busy;
        mon_a.pred       = bus.predecessor;
        mon_a.succ       = bus.successor;
        mon_a.outs       = bus.outstanding;
        mon_a.cerr       = bus.cnt_err;
        mon_a.terr       = bus.timeout_err;
        checks++;
        if (mon_a !== mon_e) begin
          failures++;
          $display("FAIL outputs t=%0t got=%h exp=%h",
                   $time, mon_a, mon_e);
        end
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0, 0);
    // free run from reset
    do_reset();
    idle(3);
    // fence with nothing in flight
    step(0, 0, 1, 32'h100, 0, 0, 0);
    step(0, 0, 0, 32'h0, 1, 0, 0);
    idle(4);
    // fence waits for two acks
    step(0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(0, 0, 0, 32'h0, 0, 0, i == 5 || i == 9);
    // redirect beats fence and stall
    step(0, 1, 1, 32'h2003, 1, 0, 0);
    idle(2);
    // fence under stall
    step(0, 1, 0, 32'h0, 1, 0, 0);
    idle(3);
    // wrap and underflow
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    idle(2);
    // counter saturation
    for (int i = 0; i < 17; i++)
      step(0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 32'h0, 0, 1, 1);
    step(0, 0, 0, 32'h0, 0, 0, 0);
    do_reset();
    // unacked op: watchdog or wait forever
    step(0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0, 0);
    idle(20);
    step(0, 0, 0, 32'h0, 0, 0, 1);
    idle(4);
    // redirect and restart abort drain
    step(0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0, 0);
    step(0, 0, 1, 32'h44, 0, 0, 0);
    step(0, 0, 0, 32'h0, 1, 0, 0);
    step(0, 0, 0, 32'h0, 0, 0, 0);
    step(1, 0, 0, 32'h0, 0, 1, 0);
    idle(2);
    // async reset in the middle of a drain
    step(0, 0, 0, 32'h0, 0, 1, 0);
    step(0, 0, 0, 32'h0, 1, 0, 0);
    idle(2);
    do_reset();
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199, 0) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(99, 0) < 2,
             $urandom_range(99, 0) < 25,
             $urandom_range(99, 0) < 8,
             32'($urandom),
             $urandom_range(99, 0) < 12,
             $urandom_range(99, 0) < 35,
             $urandom_range(99, 0) < 35);
      end
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d left, exp=0",
               sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
